digit_entry: RTL and testbench
==============================

DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the consecutive differing samples required to accept a button change (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock (100 MHz on board).
REQ-003 SHALL have port reset  input  1  reset, synchronous to clk, active-high.
REQ-004 SHALL have port btn  input  1  raw asynchronous load pushbutton.
REQ-005 SHALL have port clr  input  1  synchronous clear of all digits and pointer.
REQ-006 SHALL have port d  input  5  entry value: d[4:1] hex digit, d[0] decimal point.
REQ-007 SHALL have ports k0..k7  output  5 each  stored digit slots, same packing as d, for the display controller.
REQ-008 SHALL have port ptr  output  3  index of the next slot to be written.
REQ-009 SHALL have port load_pulse  output  1  one-cycle strobe per accepted press.

Function
REQ-010 SHALL pass btn through a two-flop synchronizer (btn_s); btn sampled at edge n is visible as btn_s after edge n+2.
REQ-011 SHALL hold debounced state "stable" and counter cnt: at each edge with btn_s != stable, if cnt == DEBOUNCE_CYCLES-1 then stable <= btn_s and cnt <= 0, else cnt <= cnt+1.
REQ-012 SHALL set cnt <= 0 on any edge where btn_s == stable (a bounce restarts the count).
REQ-013 SHALL register load_pulse high for exactly one cycle, on the edge after stable goes 0->1; a 1->0 change SHALL produce no pulse.
REQ-014 SHALL, on the edge where load_pulse is high, write d into slot k[ptr] and set ptr <= ptr+1 mod 8 (7 wraps to 0, overwriting k0 on the next load).
REQ-015 SHALL leave the other slots unchanged on a write.
REQ-016 SHALL, when clr is high at an edge, set all k to 0 and ptr to 0; clr SHALL take priority over a simultaneous write, and that load SHALL be discarded.
REQ-017 SHALL NOT let clr affect the synchronizer, the debouncer or load_pulse.
REQ-018 SHALL treat a button held longer than DEBOUNCE_CYCLES as a single press.
REQ-019 SHALL sample d only on the write edge; changes to d at other times SHALL have no effect.

Reset
REQ-020 SHALL, while reset is high at an edge, clear the synchronizer flops, stable, cnt, load_pulse, ptr and k0..k7 to 0.
REQ-021 SHALL discard any press in progress when reset is asserted mid-count; a button still held after reset is released SHALL be re-debounced from cnt=0 and produce one pulse.
REQ-022 SHALL give reset priority over clr and over a pending write.

Configuration
REQ-023 SHALL define shift mode under macro DIGIT_ENTRY_SHIFT_EN: each load SHALL set k7<=k6, ..., k1<=k0, k0<=d; ptr SHALL still count loads mod 8; clr and reset behaviour SHALL be unchanged.
REQ-024 SHALL use the indexed-write behaviour of REQ-014 when DIGIT_ENTRY_SHIFT_EN is undefined.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 SHALL cover: btn 0->1 sampled at edge 0 and held -> stable=1 after edge 6; load_pulse=1 only between edges 7 and 8; k0=d after edge 8; ptr=1.
REQ-026 SHALL cover: btn high 3 samples, low 1 sample, then high -> no pulse until 4 consecutive high btn_s samples; exactly one pulse per release/press cycle.
REQ-027 SHALL cover: 9 presses with d=0x02,0x04,...,0x12 -> ptr wraps 7->0->1; k0=0x12; k1..k7 hold the 2nd..8th values.
REQ-028 SHALL cover: clr high on the same edge as load_pulse -> all k=0, ptr=0, no write.
REQ-029 SHALL cover: reset at cnt=2 with btn held, reset then released -> load_pulse not seen before 4 fresh samples; exactly one pulse afterwards.
REQ-030 SHALL cover: with DIGIT_ENTRY_SHIFT_EN, loads d=0x03 then 0x05 -> k0=0x05, k1=0x03, k2..k7=0.

Source files
------------

// File: rtl/digit_entry.sv
// Debounced pushbutton loader that stores 5-bit digit entries into eight display slots.
// Optional macro DIGIT_ENTRY_SHIFT_EN turns slot writes into a shift register fed at k0.
module digit_entry #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       clr,
    input  logic [4:0] d,
    output logic [4:0] k0,
    output logic [4:0] k1,
    output logic [4:0] k2,
    output logic [4:0] k3,
    output logic [4:0] k4,
    output logic [4:0] k5,
    output logic [4:0] k6,
    output logic [4:0] k7,
    output logic [2:0] ptr,
    output logic       load_pulse
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          btn_s_reg;
    logic          stable_reg;
    logic          stable_prev_reg;
    logic [CW-1:0] cnt_reg;
    logic          load_pulse_reg;
    logic [2:0]    ptr_reg;
    logic [2:0]    ptr_next;
    logic [39:0]   slots_flat;

    // Synchronizer, debounce counter and rising-edge strobe; clr never touches these.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg       <= 1'b0;
            btn_s_reg       <= 1'b0;
            stable_reg      <= 1'b0;
            stable_prev_reg <= 1'b0;
            cnt_reg         <= '0;
            load_pulse_reg  <= 1'b0;
        end else begin
            sync1_reg       <= btn;
            btn_s_reg       <= sync1_reg;
            stable_prev_reg <= stable_reg;
            load_pulse_reg  <= stable_reg & ~stable_prev_reg;
            if (btn_s_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                stable_reg <= btn_s_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (clr) begin
            ptr_next = '0;
        end else if (load_pulse_reg) begin
            ptr_next = ptr_reg + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_slot
        logic [4:0] slot_reg;
        logic [4:0] slot_next;
`ifdef DIGIT_ENTRY_SHIFT_EN
        logic [4:0] shift_src;
        if (gi == 0) begin : g_head
            assign shift_src = d;
        end else begin : g_body
            assign shift_src = slots_flat[(gi-1)*5 +: 5];
        end
`endif

        // clr wins over a load arriving on the same edge.
        always_comb begin
            slot_next = slot_reg;
`ifdef DIGIT_ENTRY_SHIFT_EN
            if (load_pulse_reg) begin
                slot_next = shift_src;
            end
`else
            if (load_pulse_reg && (ptr_reg == 3'(gi))) begin
                slot_next = d;
            end
`endif
            if (clr) begin
                slot_next = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                slot_reg <= '0;
            end else begin
                slot_reg <= slot_next;
            end
        end

        assign slots_flat[gi*5 +: 5] = slot_reg;
    end

    assign k0         = slots_flat[4:0];
    assign k1         = slots_flat[9:5];
    assign k2         = slots_flat[14:10];
    assign k3         = slots_flat[19:15];
    assign k4         = slots_flat[24:20];
    assign k5         = slots_flat[29:25];
    assign k6         = slots_flat[34:30];
    assign k7         = slots_flat[39:35];
    assign ptr        = ptr_reg;
    assign load_pulse = load_pulse_reg;

endmodule

// File: tb/tb_digit_entry.sv
// Directed plus randomized bench for digit_entry with DEBOUNCE_CYCLES=4 and a queue-based reference model.
module tb_digit_entry;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn = 1'b0;
    logic       clr = 1'b0;
    logic [4:0] d = '0;
    logic [4:0] k0, k1, k2, k3, k4, k5, k6, k7;
    logic [2:0] ptr;
    logic       load_pulse;

    int checks = 0;
    int failures = 0;

    digit_entry #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .reset(reset), .btn(btn), .clr(clr), .d(d),
        .k0(k0), .k1(k1), .k2(k2), .k3(k3), .k4(k4), .k5(k5), .k6(k6), .k7(k7),
        .ptr(ptr), .load_pulse(load_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: btn seen after two edges, a button change is accepted once
    // N consecutive synchronized samples disagree with the accepted level.
    logic       m_in1 = 0, m_btn_s = 0, m_stable = 0, m_rose = 0, m_pulse = 0;
    logic       m_win[$];
    logic [2:0] m_ptr = 0;
    logic [4:0] m_k[8];

    int scen_edge, pulse_cnt, first_pulse;
    int run_len;
    logic rb;

    function automatic logic [39:0] m_pack();
        logic [39:0] v;
        for (int j = 0; j < 8; j++) v[j*5 +: 5] = m_k[j];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic b, input logic c, input logic [4:0] dv, input logic r);
        logic rose_now;
        rose_now = 1'b0;
        if (r) begin
            m_in1 = 0; m_btn_s = 0; m_stable = 0; m_rose = 0; m_pulse = 0; m_ptr = 0;
            m_win.delete();
            for (int j = 0; j < 8; j++) m_k[j] = '0;
        end else begin
            if (c) begin
                for (int j = 0; j < 8; j++) m_k[j] = '0;
                m_ptr = 0;
            end else if (m_pulse) begin
`ifdef DIGIT_ENTRY_SHIFT_EN
                for (int j = 7; j > 0; j--) m_k[j] = m_k[j-1];
                m_k[0] = dv;
`else
                m_k[m_ptr] = dv;
`endif
                m_ptr = m_ptr + 3'd1;
            end
            m_pulse = m_rose;
            if (m_btn_s == m_stable) begin
                m_win.delete();
            end else begin
                m_win.push_back(m_btn_s);
                if (m_win.size() == N) begin
                    m_stable = m_btn_s;
                    m_win.delete();
                    rose_now = m_stable;
                end
            end
            m_rose = rose_now;
            m_btn_s = m_in1;
            m_in1 = b;
        end
    endtask

    task automatic tick(input logic b, input logic c, input logic [4:0] dv, input logic r);
        btn = b; clr = c; d = dv; reset = r;
        model_edge(b, c, dv, r);
        @(posedge clk);
        #1;
        scen_edge++;
        if (load_pulse === 1'b1) begin
            pulse_cnt++;
            if (first_pulse < 0) first_pulse = scen_edge;
        end
        chk("load_pulse", 64'(load_pulse), 64'(m_pulse));
        chk("ptr", 64'(ptr), 64'(m_ptr));
        chk("slots", 64'({k7, k6, k5, k4, k3, k2, k1, k0}), 64'(m_pack()));
    endtask

    task automatic scen_start();
        scen_edge = 0; pulse_cnt = 0; first_pulse = -1;
    endtask

    task automatic press(input logic [4:0] dv);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, dv, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, dv, 1'b0);
    endtask

    initial begin
        for (int j = 0; j < 8; j++) m_k[j] = '0;
        scen_start();

        // Reset state
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 5'h1f, 1'b1);
        chk("reset_ptr", 64'(ptr), 64'd0);
        chk("reset_pulse", 64'(load_pulse), 64'd0);
        chk("reset_slots", 64'({k7, k6, k5, k4, k3, k2, k1, k0}), 64'd0);
        tick(1'b0, 1'b0, 5'h00, 1'b0);

        // Single long press: pulse after edge 7, k0 written at edge 8
        scen_start();
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0, 5'h0b, 1'b0);
            if (scen_edge == 8) chk("req025_k0_at_edge8", 64'(k0), 64'h0b);
        end
        chk("req025_first_pulse", 64'(first_pulse), 64'd7);
        chk("req025_ptr", 64'(ptr), 64'd1);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 5'($urandom), 1'b0);
        chk("req025_one_pulse", 64'(pulse_cnt), 64'd1);
        chk("req025_k0_hold", 64'(k0), 64'h0b);

        // Bounce: 3 high, 1 low, then held high
        scen_start();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 5'h07, 1'b0);
        tick(1'b0, 1'b0, 5'h07, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 5'h07, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 5'h07, 1'b0);
        chk("req026_first_pulse", 64'(first_pulse), 64'd11);
        chk("req026_one_pulse", 64'(pulse_cnt), 64'd1);

        // Nine presses wrap the pointer
        tick(1'b0, 1'b1, 5'h00, 1'b0);
        scen_start();
        for (int i = 1; i <= 9; i++) press(5'(2 * i));
        chk("req027_pulses", 64'(pulse_cnt), 64'd9);
        chk("req027_ptr", 64'(ptr), 64'd1);
`ifndef DIGIT_ENTRY_SHIFT_EN
        chk("req027_k0", 64'(k0), 64'h12);
        chk("req027_k1_k7", 64'({k7, k6, k5, k4, k3, k2, k1}), 64'({5'h10, 5'h0e, 5'h0c, 5'h0a, 5'h08, 5'h06, 5'h04}));
`endif

        // clr on the same edge as load_pulse discards the load
        for (int i = 0; i < 20 && !m_pulse; i++) tick(1'b1, 1'b0, 5'h15, 1'b0);
        chk("req028_pulse_present", 64'(load_pulse), 64'd1);
        tick(1'b1, 1'b1, 5'h15, 1'b0);
        chk("req028_ptr", 64'(ptr), 64'd0);
        chk("req028_slots", 64'({k7, k6, k5, k4, k3, k2, k1, k0}), 64'd0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 5'h15, 1'b0);

        // Reset mid-count with button held
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 5'h09, 1'b0);
        tick(1'b1, 1'b0, 5'h09, 1'b1);
        tick(1'b1, 1'b0, 5'h09, 1'b1);
        chk("req029_reset_pulse", 64'(load_pulse), 64'd0);
        scen_start();
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 5'h09, 1'b0);
        chk("req029_first_pulse", 64'(first_pulse), 64'd7);
        chk("req029_one_pulse", 64'(pulse_cnt), 64'd1);
        chk("req029_k0", 64'(k0), 64'h09);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 5'h09, 1'b0);

`ifdef DIGIT_ENTRY_SHIFT_EN
        tick(1'b0, 1'b1, 5'h00, 1'b0);
        press(5'h03);
        press(5'h05);
        chk("req030_k0", 64'(k0), 64'h05);
        chk("req030_k1", 64'(k1), 64'h03);
        chk("req030_k2_k7", 64'({k7, k6, k5, k4, k3, k2}), 64'd0);
`endif

        // Randomized bouncing, data churn, occasional clr and reset
        run_len = 0;
        rb = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (run_len == 0) begin
                rb = 1'($urandom_range(0, 1));
                run_len = $urandom_range(1, 9);
            end
            run_len--;
            tick(rb, 1'($urandom_range(0, 39) == 0), 5'($urandom), 1'($urandom_range(0, 149) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
